serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_fulladder.sv | 16 +
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the default operand width.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder used by the serial adder data path.
module serial_adder_fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and carry-out of one bit position
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a + b + cin one bit per clock, LSB first,
// through a single full adder. Result and carry are registered and held
// until the next result is loaded.
// Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow output (ovf).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 sum bits produced so far; the final bit comes
    // straight from the adder when the result is loaded.
    logic [WIDTH-2:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last;

    // Final bit of the current operation is being processed this cycle
    always_comb begin
        last = (cnt == CW'(WIDTH - 1));
    end

    serial_adder_fulladder fulladder (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Control FSM, operand/result shifting and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        res_sh <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    // New bit enters at the top; truncation drops the oldest slot
                    res_sh <= (WIDTH - 1)'({fa_s, res_sh} >> 1);
                    carry  <= fa_co;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= {fa_s, res_sh};
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ fa_co;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases
// followed by randomized operations against an arithmetic reference.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         exp_ovf;
`endif

    logic [W-1:0] exp_sum;
    logic         exp_cout;

    int n_cmp;
    int n_err;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result();
        check("sum", sum, exp_sum);
        check("cout", cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, exp_ovf);
`endif
    endtask

    // Start an addition now (IDLE or DONE cycle) and follow it to its done cycle.
    // intrude > 0 re-asserts start with junk operands in that busy cycle.
    task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_c, input int intrude);
        logic [W:0] full;
        full = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, op_c};
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        cin   = op_c;
        tick();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        for (int i = 1; i <= int'(W); i++) begin
            if (i == intrude) begin
                start = 1'b1;
                a     = 8'hAA;
            end else begin
                start = 1'b0;
            end
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check_result();
            tick();
        end
        start    = 1'b0;
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
`ifdef SERIAL_ADDER_OVF_EN
        exp_ovf  = (op_a[W-1] == op_b[W-1]) && (exp_sum[W-1] != op_a[W-1]);
`endif
        check("busy_done", busy, 0);
        check("done_pulse", done, 1);
        check_result();
    endtask

    task automatic idle_tick();
        start = 1'b0;
        tick();
        check("busy_idle", busy, 0);
        check("done_idle", done, 0);
        check_result();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        exp_ovf  = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_result();

        // Start on the very first edge after reset release
        rst_n = 1'b1;
        run_op(8'h0F, 8'h01, 1'b0, 0);
        idle_tick();
        run_op(8'hFF, 8'h01, 1'b0, 0);
        idle_tick();
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        idle_tick();
        run_op(8'h7F, 8'h01, 1'b0, 0);
        idle_tick();
        run_op(8'h80, 8'h80, 1'b0, 0);
        idle_tick();
        run_op(8'h05, 8'h03, 1'b0, 0);
        idle_tick();

        // Start re-asserted mid-run must be ignored
        run_op(8'h12, 8'h34, 1'b0, 3);
        idle_tick();
        idle_tick();

        // Reset in the middle of a run
        start = 1'b1;
        a     = 8'h3C;
        b     = 8'h55;
        cin   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        exp_ovf  = 1'b0;
`endif
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check_result();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < int'(W) + 2; i++) idle_tick();
        run_op(8'h3C, 8'h55, 1'b1, 0);

        // Back-to-back: new start in the done cycle
        run_op(8'h01, 8'h02, 1'b0, 0);
        idle_tick();

        // Randomized operations with random gaps and occasional intrusions
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) idle_tick();
            end
        end
        idle_tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
